// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding and default sizing constants used
// by the transmit queue and the reusable synchronous FIFO.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_TXQ_DEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE,
      GAP
   } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host/transmitter handshake bundle for uart_tx_queue.
// Optional macro: UART_TX_QUEUE_LEVEL_EN adds the 'level' occupancy signal.
interface uart_tx_queue_if
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = UART_TXQ_DEPTH
);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] tx_data_in;
   logic                  start;
   logic                  tx_active;
   logic                  done_tx;
   logic                  busy;
`ifdef UART_TX_QUEUE_LEVEL_EN
   logic [$clog2(DEPTH):0] level;

   modport slave (
      input  wr_en, wr_data, tx_active, done_tx,
      output full, empty, tx_data_in, start, busy, level
   );

   modport master (
      output wr_en, wr_data, tx_active, done_tx,
      input  full, empty, tx_data_in, start, busy, level
   );
`else
   modport slave (
      input  wr_en, wr_data, tx_active, done_tx,
      output full, empty, tx_data_in, start, busy
   );

   modport master (
      output wr_en, wr_data, tx_active, done_tx,
      input  full, empty, tx_data_in, start, busy
   );
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; shared by the UART TX and RX paths.
// Optional macro: UART_TX_QUEUE_LEVEL_EN adds a registered occupancy count.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = UART_TXQ_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   full,
`ifdef UART_TX_QUEUE_LEVEL_EN
   output logic [$clog2(DEPTH):0] level,
`endif
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_accept;
   logic                  rd_accept;

   // A write while full is dropped even if a pop happens in the same cycle,
   // because 'full' reflects only the registered pointers.
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // Advance each pointer independently on an accepted write or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers; clearing them is enough to discard stored contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array has no reset; stale entries are unreachable after reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

`ifdef UART_TX_QUEUE_LEVEL_EN
   logic [AW:0] level_q, level_d;

   // Occupancy follows the next pointer values so it updates with them.
   always_comb begin
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // Registered occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding a UART transmitter one frame at a time.
// Optional macro: UART_TX_QUEUE_LEVEL_EN exposes the FIFO occupancy as 'level'.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = UART_TXQ_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_queue_if.slave  bus
);

   txq_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.wr_en),
      .wr_data (bus.wr_data),
      .rd_en   (pop),
      .rd_data (head_data),
      .full    (fifo_full),
`ifdef UART_TX_QUEUE_LEVEL_EN
      .level   (bus.level),
`endif
      .empty   (fifo_empty)
   );

   // Next-state logic: pop in IDLE when a byte waits and the line is free,
   // pulse start once, hold until the frame completes, then insert a gap.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !bus.tx_active) begin
               pop       = 1'b1;
               tx_data_d = head_data;
               state_d   = START;
            end
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.done_tx) begin
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and outgoing-byte registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign bus.start      = (state_q == START);
   assign bus.busy       = (state_q != IDLE);
   assign bus.tx_data_in = tx_data_q;
   assign bus.full       = fifo_full;
   assign bus.empty      = fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table plus directed sequences
// for burst, overflow, mid-frame reset and stall behaviour.
module tb_uart_tx_queue;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   uart_tx_queue_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

   uart_tx_queue #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       tx_active;
      logic       done_tx;
      logic       exp_start;
      logic       exp_busy;
      logic       exp_empty;
      logic [7:0] exp_txd;
   } vec_t;

   vec_t vecs [12];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic wr_en, input logic [7:0] wr_data,
                                 input logic tx_active, input logic done_tx);
      bus.wr_en     = wr_en;
      bus.wr_data   = wr_data;
      bus.tx_active = tx_active;
      bus.done_tx   = done_tx;
   endtask

   task automatic wait_start(input int budget, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         cyc++;
         if (bus.start === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " full"},  bus.full, 0);
      check_output({tag, " empty"}, bus.empty, 1);
      check_output({tag, " start"}, bus.start, 0);
      check_output({tag, " busy"},  bus.busy, 0);
      check_output({tag, " txd"},   bus.tx_data_in, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check_output({tag, " level"}, bus.level, 0);
`endif
   endtask

   initial begin
      int         cyc;
      bit         ok;
      int         n;
      logic [7:0] burst [3];

      total = 0;
      bad   = 0;
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check_reset_outputs("por");
      tick();
      tick();
      rst = 1'b1;
      tick();

      // wr, data, txa, done, start, busy, empty, txd
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].tx_active,
                        vecs[i].done_tx);
         tick();
         check_output($sformatf("vec%0d start", i), bus.start, vecs[i].exp_start);
         check_output($sformatf("vec%0d busy", i),  bus.busy,  vecs[i].exp_busy);
         check_output($sformatf("vec%0d empty", i), bus.empty, vecs[i].exp_empty);
         check_output($sformatf("vec%0d full", i),  bus.full,  0);
         check_output($sformatf("vec%0d txd", i),   bus.tx_data_in, vecs[i].exp_txd);
      end
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick();

      // Burst of three bytes on consecutive cycles.
      burst[0] = 8'h11;
      burst[1] = 8'h22;
      burst[2] = 8'h33;
      apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
      tick();
      bus.wr_data = 8'h22;
      tick();
      check_output("burst first start", bus.start, 1);
      check_output("burst first txd", bus.tx_data_in, 8'h11);
      bus.wr_data = 8'h33;
      tick();
      bus.wr_en = 1'b0;
      check_output("burst first pulse width", bus.start, 0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            wait_start(10, cyc, ok);
            check_output($sformatf("burst%0d start seen", i), ok, 1);
            check_output($sformatf("burst%0d txd", i), bus.tx_data_in, burst[i]);
            check_output($sformatf("burst%0d gap>=3", i), (cyc + 1) >= 3, 1);
            tick();
            check_output($sformatf("burst%0d pulse width", i), bus.start, 0);
         end
         n = 0;
         repeat (10) begin
            tick();
            if (bus.start === 1'b1) n++;
         end
         check_output($sformatf("burst%0d no start while withheld", i), n, 0);
         check_output($sformatf("burst%0d txd held", i), bus.tx_data_in, burst[i]);
         bus.done_tx = 1'b1;
         tick();
         bus.done_tx = 1'b0;
      end
      tick();
      check_output("burst end busy", bus.busy, 0);
      check_output("burst end empty", bus.empty, 1);
      check_output("burst end txd kept", bus.tx_data_in, 8'h33);

      // Overflow with the transmitter stalled.
      bus.tx_active = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(i);
         tick();
      end
      bus.wr_en = 1'b0;
      check_output("ovf full", bus.full, 1);
      check_output("ovf busy stalled", bus.busy, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check_output("ovf level 16", bus.level, 16);
`endif
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hFF;
      tick();
      bus.wr_en = 1'b0;
      check_output("ovf still full", bus.full, 1);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check_output("ovf level after drop", bus.level, 16);
`endif
      bus.tx_active = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wait_start(10, cyc, ok);
         check_output($sformatf("drain%0d start seen", i), ok, 1);
         check_output($sformatf("drain%0d txd", i), bus.tx_data_in, 8'(i));
         tick();
         bus.done_tx = 1'b1;
         tick();
         bus.done_tx = 1'b0;
      end
      wait_start(10, cyc, ok);
      check_output("drain no extra byte", ok, 0);
      check_output("drain empty", bus.empty, 1);
      check_output("drain not full", bus.full, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check_output("drain level 0", bus.level, 0);
`endif

      // Reset in the middle of a frame with four bytes still queued.
      apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.wr_data = 8'hA1 + 8'(i);
         tick();
      end
      bus.wr_en = 1'b0;
      check_output("midrst busy before", bus.busy, 1);
      check_output("midrst empty before", bus.empty, 0);
      check_output("midrst start before", bus.start, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check_output("midrst level before", bus.level, 4);
`endif
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      tick();
      rst = 1'b1;
      n = 0;
      repeat (20) begin
         tick();
         if (bus.start === 1'b1) n++;
      end
      check_output("midrst no start after release", n, 0);
      check_output("midrst still empty", bus.empty, 1);

      // Stall via tx_active with two bytes queued.
      apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b0);
      tick();
      bus.wr_data = 8'h6B;
      tick();
      bus.wr_en = 1'b0;
      n = 0;
      repeat (5) begin
         tick();
         if (bus.start === 1'b1) n++;
      end
      check_output("stall no start", n, 0);
      check_output("stall not busy", bus.busy, 0);
      bus.tx_active = 1'b0;
      tick();
      check_output("stall release start", bus.start, 1);
      check_output("stall release txd", bus.tx_data_in, 8'h5A);
      tick();
      check_output("stall pulse width", bus.start, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue placed directly upstream of the UART transmitter. It accepts bytes from the host in single-cycle writes and buffers them in a DEPTH-entry FIFO. It then feeds them one at a time into the transmitter's `tx_data_in` and `start` inputs, waiting for the transmitter's `done_tx` before launching the next byte. This decouples bursty host writes from the slow serial bit rate.

## Interface
- `DATA_WIDTH`, 8, byte width; matches the transmitter's `DATA_WIDTH`.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  host write strobe.
- `wr_data`  in  DATA_WIDTH  host byte.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `tx_data_in`  out  DATA_WIDTH  byte presented to the transmitter.
- `start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_active`  in  1  transmitter is shifting a frame.
- `done_tx`  in  1  transmitter frame-complete pulse.
- `busy`  out  1  a byte is in flight (FSM not IDLE).

## Operation
- FIFO storage:
  - Read and write pointers are `$clog2(DEPTH)+1` bits wide. The MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = indices equal and wrap bits differ.
- Write: accepted when `wr_en && !full`. A write while `full` is dropped silently, even if a pop occurs in the same cycle.
- Pop: performed only by the FSM. When a write and a pop occur in the same cycle, both take effect and the count is unchanged.
- FSM states: IDLE, START, WAIT_DONE, GAP.
  - IDLE: on `!empty && !tx_active`, pop the head into the `tx_data_in` register and go to START.
  - START: `start`=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: `tx_data_in` is held stable. On `done_tx`=1, go to GAP. `done_tx` arriving in any other state is ignored.
  - GAP: one idle cycle guaranteeing a gap between frames; go to IDLE.
- `busy` = state ≠ IDLE.
- `tx_data_in` keeps its last value after GAP. It changes only on a pop.
- Reset (asynchronous, any state, including mid-frame):
  - Pointers cleared and FIFO contents discarded.
  - State → IDLE.
- Reset values of all outputs:
  - `full`=0, `empty`=1, `start`=0, `busy`=0.
  - `tx_data_in`=0.
  - `level`=0 when compiled in.

## Timing
- `full` and `empty` are registered-pointer functions. They update the cycle after the write or pop edge.
- Write accepted at edge N into an empty queue with the FSM in IDLE: `empty`=0 after N, pop at edge N+1, `start`=1 during the cycle after edge N+1, i.e. a latency of 2 cycles.
- Back-to-back bytes: the next `start` comes no earlier than 3 cycles after the `done_tx` cycle (GAP, IDLE, START).
- Throughput is bounded by the transmitter. The queue never issues `start` while in WAIT_DONE.
- When `tx_active`=1 in IDLE (the transmitter is busy from elsewhere), the pop is stalled until `tx_active`=0.

## Configuration
- Macro: `UART_TX_QUEUE_LEVEL_EN`.
- Defined: an extra output `level` (out, `$clog2(DEPTH)+1` bits) gives the current entry count, 0..DEPTH. It is registered, updates with the pointers, and resets to 0.
- Undefined: the port is absent and there is no count logic. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `txq_state_t` (IDLE, START, WAIT_DONE, GAP).
  - Default constants `UART_DATA_WIDTH`=8 and `UART_TXQ_DEPTH`=16.
- Sub-module `uart_sync_fifo`:
  - Storage, pointers, `full`/`empty`, and the optional `level`.
  - Reused later for the RX side.
- The FSM and `tx_data_in` register live in `uart_tx_queue`.

## Test plan
- Reset: drive `rst`=0 mid-simulation → `full`=0, `empty`=1, `start`=0, `busy`=0, `tx_data_in`=0 immediately, without waiting for a clock edge.
- Single byte:
  - Write 0xA5 at edge N → `start`=1 for one cycle after edge N+1, with `tx_data_in`=0xA5.
  - Pulse `done_tx` 10 cycles later → `busy`=0 two cycles after that.
- Burst: write 0x11, 0x22, 0x33 on consecutive cycles → three `start` pulses carrying 0x11, 0x22, 0x33 in order. Each pulse comes ≥3 cycles after the previous `done_tx`. No pulse occurs while `done_tx` is withheld.
- Overflow: with the FSM stalled (`tx_active`=1), write 16 bytes 0x00..0x0F, then 0xFF → `full`=1 and 0xFF is dropped. The drain emits 0x00..0x0F only. With `UART_TX_QUEUE_LEVEL_EN`, `level` reads 16 then falls to 0.
- Reset mid-frame: with 4 entries queued and the FSM in WAIT_DONE, assert `rst` → `empty`=1, `busy`=0. After release, no `start` occurs for 20 cycles.
- Stall: hold `tx_active`=1 with 2 entries queued → `start` stays 0. Drop `tx_active` → `start`=1 for one cycle, 1 cycle later.
